// File: rtl/ray_sched_pkg.sv
// Shared types and constants for the ray batch scheduler.
//   sched_state_e : scheduler FSM states
//   RAY_W         : packed ray width {dir z,y,x, origin z,y,x}, Q16.16 each
//   FIP_MAX       : "no hit" t value, largest positive Q16.16
package ray_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ARM,
    BUSY,
    FLUSH,
    RESP
  } sched_state_e;

  localparam int RAY_W = 192;
  localparam logic signed [31:0] FIP_MAX = 32'sh7fffffff;

endpackage

// File: rtl/ray_batch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit at or
// after ptr, wrapping around.
//   req       : request vector
//   ptr       : priority pointer, index of the highest-priority requester
//   grant     : one-hot grant (all zero when req is zero)
//   grant_idx : encoded index of the granted requester
module rr_arbiter
  import ray_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] pos_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    pos_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // one spare bit so ptr + i cannot overflow before the wrap
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      pos_idx = pos[IDX_W-1:0];
      if (!found && req[pos_idx]) begin
        found          = 1'b1;
        grant[pos_idx] = 1'b1;
        grant_idx      = pos_idx;
      end
    end
  end

endmodule

// File: rtl/ray_batch_scheduler.sv
// Shares one triangle-intersection batch engine among NREQ ray requesters.
// Round-robin grant, payload capture, batch launch, watchdog with engine
// flush, closest-hit result returned to the winner.
//   i_clk, i_rstn          : clock, synchronous active-low reset
//   i_req/i_ray/i_baseaddr/i_tri_cnt : per-requester request and payload
//   o_ack, o_resp_valid    : one-hot one-cycle pulses to the requesters
//   o_hit/o_t/o_tri_index/o_timeout  : result, held until the next response
//   o_busy                 : scheduler not idle
//   o_ins_*                : engine launch interface and engine reset
//   i_ins_*                : engine completion and result
//
// state  | meaning
// IDLE   | sample requests, grant and capture payload
// LAUNCH | pulse engine start
// ARM    | let the engine drop its finish flag, clear watchdog
// BUSY   | wait for finish or watchdog expiry
// FLUSH  | two cycles of engine reset after a hang
// RESP   | return result to the granted requester, advance pointer
module ray_batch_scheduler
  import ray_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int CNT_W       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*RAY_W-1:0] i_ray,
  input  logic [NREQ*32-1:0]    i_baseaddr,
  input  logic [NREQ*32-1:0]    i_tri_cnt,
  output logic [NREQ-1:0]       o_ack,
  output logic [NREQ-1:0]       o_resp_valid,
  output logic                  o_hit,
  output logic [31:0]           o_t,
  output logic [31:0]           o_tri_index,
  output logic                  o_timeout,
  output logic                  o_busy,
  output logic                  o_ins_ivalid,
  output logic                  o_ins_reset,
  output logic [31:0]           o_ins_baseaddr,
  output logic [RAY_W-1:0]      o_ins_ray,
  output logic [31:0]           o_ins_tri_cnt,
  input  logic                  i_ins_finish,
  input  logic                  i_ins_hit,
  input  logic [31:0]           i_ins_t,
  input  logic [31:0]           i_ins_tri_index
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, sel_q, sel_d;
  logic [RAY_W-1:0] ray_q, ray_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wd_q, wd_d;
  logic             flush_cnt_q, flush_cnt_d;
  logic             res_hit_q, res_hit_d, res_to_q, res_to_d;
  logic [31:0]      res_t_q, res_t_d, res_idx_q, res_idx_d;
  logic [NREQ-1:0]  ack_q, ack_d, resp_valid_q, resp_valid_d;
  logic             hit_q, hit_d, timeout_q, timeout_d;
  logic [31:0]      t_q, t_d, tri_idx_q, tri_idx_d;

  logic [NREQ-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic [RAY_W-1:0] ray_sel;
  logic [31:0]      base_sel, cnt_sel;
  logic             ins_ivalid, flush_active;

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
    .req       (i_req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    ray_sel  = '0;
    base_sel = '0;
    cnt_sel  = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (arb_idx == IDX_W'(r)) begin
        ray_sel  = i_ray[RAY_W*r +: RAY_W];
        base_sel = i_baseaddr[32*r +: 32];
        cnt_sel  = i_tri_cnt[32*r +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    ray_d        = ray_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    flush_cnt_d  = flush_cnt_q;
    res_hit_d    = res_hit_q;
    res_t_d      = res_t_q;
    res_idx_d    = res_idx_q;
    res_to_d     = res_to_q;
    ack_d        = '0;
    resp_valid_d = '0;
    hit_d        = hit_q;
    t_d          = t_q;
    tri_idx_d    = tri_idx_q;
    timeout_d    = timeout_q;
    ins_ivalid   = 1'b0;
    flush_active = 1'b0;

    case (state_q)
      IDLE: begin
        if (|i_req) begin
          sel_d  = arb_idx;
          ray_d  = ray_sel;
          base_d = base_sel;
          cnt_d  = CNT_W'(cnt_sel);
          ack_d  = arb_grant;
          if (cnt_sel != '0) begin
            state_d = LAUNCH;
          end else begin
            // the engine would underflow on cnt-1, so answer locally
            res_hit_d = 1'b0;
            res_t_d   = FIP_MAX;
            res_idx_d = '0;
            res_to_d  = 1'b0;
            state_d   = RESP;
          end
        end
      end
      LAUNCH: begin
        ins_ivalid = 1'b1;
        state_d    = ARM;
      end
      ARM: begin
        wd_d    = '0;
        state_d = BUSY;
      end
      BUSY: begin
        wd_d = wd_q + 1'b1;
        if (i_ins_finish) begin
          res_hit_d = i_ins_hit;
          res_t_d   = i_ins_t;
          res_idx_d = i_ins_tri_index;
          res_to_d  = 1'b0;
          state_d   = RESP;
        end else if (wd_q == WD_LAST) begin
          flush_cnt_d = 1'b0;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        flush_active = 1'b1;
        res_hit_d    = 1'b0;
        res_t_d      = FIP_MAX;
        res_idx_d    = '0;
        res_to_d     = 1'b1;
        flush_cnt_d  = 1'b1;
        if (flush_cnt_q) state_d = RESP;
      end
      RESP: begin
        resp_valid_d = NREQ'(1) << sel_q;
        hit_d        = res_hit_q;
        t_d          = res_t_q;
        tri_idx_d    = res_idx_q;
        timeout_d    = res_to_q;
        ptr_d        = (sel_q == IDX_W'(NREQ-1)) ? '0 : sel_q + 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      sel_q        <= '0;
      ray_q        <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      wd_q         <= '0;
      flush_cnt_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_t_q      <= '0;
      res_idx_q    <= '0;
      res_to_q     <= 1'b0;
      ack_q        <= '0;
      resp_valid_q <= '0;
      hit_q        <= 1'b0;
      t_q          <= '0;
      tri_idx_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      ray_q        <= ray_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      flush_cnt_q  <= flush_cnt_d;
      res_hit_q    <= res_hit_d;
      res_t_q      <= res_t_d;
      res_idx_q    <= res_idx_d;
      res_to_q     <= res_to_d;
      ack_q        <= ack_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      t_q          <= t_d;
      tri_idx_q    <= tri_idx_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_ack          = ack_q;
  assign o_resp_valid   = resp_valid_q;
  assign o_hit          = hit_q;
  assign o_t            = t_q;
  assign o_tri_index    = tri_idx_q;
  assign o_timeout      = timeout_q;
  assign o_busy         = (state_q != IDLE);
  assign o_ins_ivalid   = ins_ivalid;
  assign o_ins_reset    = ~i_rstn | flush_active;
  assign o_ins_baseaddr = base_q;
  assign o_ins_ray      = ray_q;
  assign o_ins_tri_cnt  = 32'(cnt_q);

endmodule
